// File: rtl/barrel_shifter_pipe_if.sv
// ----------------------------------------------------------------------------
// barrel_shifter_pipe_if
//   Bundles the input-beat and output-result handshakes of the pipelined
//   barrel shifter.
//
//   Handshake rules, for both the input and the output side:
//     a beat moves on a rising edge only when its valid and its ready are
//     both 1. A producer holding valid high keeps its payload stable until
//     that edge. in_ready/advance may depend combinationally on out_ready.
//
//   Signals:
//     in_valid, in_ready     input beat handshake
//     d_in                   operand (WIDTH bits)
//     shift_dir              0 = right, 1 = left
//     shift_op               00 logical, 01 arithmetic, 1x rotate
//     shift_amount           shift distance, 0..WIDTH-1
//     out_valid, out_ready   result handshake
//     d_out                  registered result (WIDTH bits)
//     busy                   some pipeline stage holds a valid beat
//
//   Modports: slave = the shifter, master = whatever drives and consumes it.
// ----------------------------------------------------------------------------
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   d_in;
    logic               shift_dir;
    logic [1:0]         shift_op;
    logic [SHAMT_W-1:0] shift_amount;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   d_out;
    logic               busy;

    modport slave (
        input  in_valid, d_in, shift_dir, shift_op, shift_amount, out_ready,
        output in_ready, out_valid, d_out, busy
    );

    modport master (
        output in_valid, d_in, shift_dir, shift_op, shift_amount, out_ready,
        input  in_ready, out_valid, d_out, busy
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// ----------------------------------------------------------------------------
// barrel_shifter_pipe
//   Logarithmic barrel shifter split into SHAMT_W = log2(WIDTH) register
//   stages. Stage i shifts by 2^i when bit i of the beat's shift amount is
//   set. The last stage register is the d_out register itself, so a result
//   is visible right after the SHAMT_W-th advancing edge (acceptance edge
//   counted as the first).
//
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous, active-high reset
//     bus   barrel_shifter_pipe_if.slave (in/out handshakes, operands,
//           d_out, busy)
//
//   Flow control: the whole pipe advances together when the output register
//   is empty or being drained (advance = !out_valid || out_ready). Bubbles
//   are not collapsed, which keeps in_ready a simple function of the output.
// ----------------------------------------------------------------------------
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    barrel_shifter_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAST    = SHAMT_W - 1;

    // Stage registers. Only the valid bits and the final data register are
    // reset; everything else is qualified by valid.
    logic [WIDTH-1:0]   st_data  [SHAMT_W];
    logic               st_dir   [SHAMT_W];
    logic [1:0]         st_op    [SHAMT_W];
    logic [SHAMT_W-1:0] st_amt   [SHAMT_W];
    logic [SHAMT_W-1:0] st_valid;

    // What each stage sees at its input: the bus for stage 0, the previous
    // stage register otherwise.
    logic [WIDTH-1:0]   src_data [SHAMT_W];
    logic               src_dir  [SHAMT_W];
    logic [1:0]         src_op   [SHAMT_W];
    logic [SHAMT_W-1:0] src_amt  [SHAMT_W];
    logic [SHAMT_W-1:0] src_valid;
    logic [WIDTH-1:0]   nxt_data [SHAMT_W];

    logic advance;

    // Shift by a fixed power of two. Arithmetic right fills with the current
    // MSB; earlier arithmetic stages preserve that MSB, so it is still the
    // sign bit of the original operand.
    function automatic logic [WIDTH-1:0] shift_pow2(
        input logic [WIDTH-1:0] d,
        input logic             dir,
        input logic [1:0]       op,
        input int               k
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (op[1]) begin
            if (dir) r = (d << k) | (d >> (WIDTH - k));
            else     r = (d >> k) | (d << (WIDTH - k));
        end else if (dir) begin
            r = d << k;
        end else if (op[0]) begin
            r = $signed(d) >>> k;
        end else begin
            r = d >> k;
        end
        return r;
    endfunction

    assign advance = !st_valid[LAST] || bus.out_ready;

    always_comb begin
        src_data[0]  = bus.d_in;
        src_dir[0]   = bus.shift_dir;
        src_op[0]    = bus.shift_op;
        src_amt[0]   = bus.shift_amount;
        src_valid[0] = bus.in_valid;
        for (int i = 1; i < SHAMT_W; i++) begin
            src_data[i]  = st_data[i-1];
            src_dir[i]   = st_dir[i-1];
            src_op[i]    = st_op[i-1];
            src_amt[i]   = st_amt[i-1];
            src_valid[i] = st_valid[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < SHAMT_W; i++) begin
            nxt_data[i] = src_amt[i][i]
                        ? shift_pow2(src_data[i], src_dir[i], src_op[i], 1 << i)
                        : src_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid      <= '0;
            st_data[LAST] <= '0;
        end else if (advance) begin
            st_valid <= src_valid;
            for (int i = 0; i < SHAMT_W; i++) begin
                st_data[i] <= nxt_data[i];
                st_dir[i]  <= src_dir[i];
                st_op[i]   <= src_op[i];
                st_amt[i]  <= src_amt[i];
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = st_valid[LAST];
    assign bus.d_out     = st_data[LAST];
    assign bus.busy      = |st_valid;

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a power of two, 2..64.
REQ-002 Derived parameter SHAMT_W = log2(WIDTH): shift-amount width and pipeline depth; default 3.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 d_in  input  WIDTH  operand.
REQ-008 shift_dir  input  1  0 = right, 1 = left.
REQ-009 shift_op  input  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate.
REQ-010 shift_amount  input  SHAMT_W  shift distance, 0..WIDTH-1.
REQ-011 out_valid  output  1  result present on d_out.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 d_out  output  WIDTH  shifted result, registered.
REQ-014 busy  output  1  high while any pipeline stage holds a valid beat.

Function
REQ-015 Accept a beat on every rising edge where in_valid and in_ready are both 1; inputs are ignored otherwise.
REQ-016 The pipeline SHALL have SHAMT_W register stages; stage i shifts by 2^i when shift_amount bit i is 1, else passes data unchanged.
REQ-017 Each stage SHALL carry data, shift_dir, shift_op, the remaining shift_amount bits and a valid bit.
REQ-018 Global advance = (not out_valid) or out_ready; all stages move together on advance and hold their contents otherwise.
REQ-019 in_ready SHALL equal advance, combinationally; no bubble collapsing.
REQ-020 Latency: the result SHALL appear on d_out with out_valid high directly after the SHAMT_W-th advancing edge, counting the acceptance edge as the first.
REQ-021 Throughput: one beat per cycle while out_ready is held 1.
REQ-022 Logical left: vacated LSBs zero. Logical right: vacated MSBs zero.
REQ-023 Arithmetic right: vacated MSBs filled with d_in[WIDTH-1]. Arithmetic left is identical to logical left.
REQ-024 Rotate, codes 10 and 11: bits leaving one end re-enter at the other, for either direction.
REQ-025 shift_amount 0 SHALL return d_in unchanged for every op and direction.
REQ-026 When out_valid = 1 and out_ready = 0, d_out and out_valid SHALL hold stable until the transfer completes.
REQ-027 Acceptance and output transfer on the same edge SHALL both complete with no beat lost or duplicated.
REQ-028 Results SHALL leave in acceptance order; stalled beats SHALL retain their op, direction and amount.
REQ-029 busy = OR of all stage valid bits, registered state only.

Reset
REQ-030 While rst = 1 at a rising edge, all stage valid bits, out_valid and busy SHALL clear to 0 and d_out to 0; in_ready SHALL then read 1.
REQ-031 Reset SHALL take priority over in_valid and out_ready; beats in flight when reset is asserted SHALL be discarded, never emitted.
REQ-032 Data registers other than d_out need no reset value; their contents are masked by the valid bits.

Verification (WIDTH = 8)
REQ-033 d_in = 8'hB1, left, logical, amount 1 -> d_out = 8'h62 after 3 advancing edges; same input with rotate -> 8'h63.
REQ-034 d_in = 8'h96, right, amount 3: logical -> 8'h12; arithmetic -> 8'hF2; rotate -> 8'hD2.
REQ-035 Stream 8 back-to-back beats with out_ready = 1 -> 8 consecutive out_valid cycles, in order, in_ready constantly 1.
REQ-036 Hold out_ready = 0 with a result pending -> d_out stable, in_ready = 0, no new beat accepted; release -> transfers resume in order with no loss or duplication.
REQ-037 Assert rst for 1 cycle with 3 beats in flight -> out_valid = 0, busy = 0 and d_out = 8'h00 next cycle; none of the 3 results ever appear.
REQ-038 Amount 0 with every op and both directions, d_in = 8'h5A -> d_out = 8'h5A.
